prog_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle MIPS core.
- Receives a framed byte stream (e.g. from a UART receiver), assembles big-endian 32-bit words and writes them into instruction memory through a write port.
- Holds the core in reset until the image is loaded and the checksum verifies, then releases it.

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Loader bus: framed byte input, instruction-memory write port and core control.
// The master drives the byte stream and reload; the loader (slave) drives the rest.
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        output rx_valid, rx_byte, reload,
        input  imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport slave (
        input  rx_valid, rx_byte, reload,
        output imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles a framed big-endian byte stream into instruction memory
// and holds the core in reset until the XOR checksum of the payload verifies.
//
// state    | meaning
// CNT_HI   | waiting for the high byte of the word count (no timeout)
// CNT_LO   | waiting for the low byte of the word count
// DATA     | assembling payload words, one write pulse per completed word
// CHK      | waiting for the checksum byte
// RUN      | image verified, core released
// ERROR    | oversize count, bad checksum or timeout; core held in reset
module prog_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 100000
) (
    input logic            clk,
    input logic            reset,
    prog_loader_if.slave   bus
);
    localparam int          IW      = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAXW    = 17'(MAX_WORDS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_RUN, S_ERROR
    } state_t;

    state_t        state, nextState;
    logic [7:0]    cntHi;
    logic [15:0]   numWords;
    logic [15:0]   wordIdx;
    logic [1:0]    byteIdx;
    logic [23:0]   asmReg;
    logic [7:0]    csum;
    logic [IW-1:0] idleCnt;
    logic [15:0]   rxCount;
    logic          countIdle;
    logic          timeoutHit;

    assign rxCount    = {cntHi, bus.rx_byte};
    assign countIdle  = (state == S_CNT_LO) || (state == S_DATA) || (state == S_CHK);
    // A byte arriving in the timeout cycle takes precedence over the timeout.
    assign timeoutHit = countIdle && !bus.rx_valid && (idleCnt == IDLE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_CNT_HI;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_CNT_HI: if (bus.rx_valid) nextState = S_CNT_LO;
            S_CNT_LO: begin
                if (bus.rx_valid) begin
                    if ({1'b0, rxCount} > MAXW) nextState = S_ERROR;
                    else if (rxCount == 16'd0)  nextState = S_CHK;
                    else                        nextState = S_DATA;
                end else if (timeoutHit) begin
                    nextState = S_ERROR;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (byteIdx == 2'd3 && wordIdx == numWords - 16'd1) nextState = S_CHK;
                end else if (timeoutHit) begin
                    nextState = S_ERROR;
                end
            end
            S_CHK: begin
                if (bus.rx_valid)    nextState = (bus.rx_byte == csum) ? S_RUN : S_ERROR;
                else if (timeoutHit) nextState = S_ERROR;
            end
            S_RUN, S_ERROR: if (bus.reload) nextState = S_CNT_HI;
            default: nextState = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 32'd0;
            bus.cpu_reset  <= 1'b1;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            cntHi          <= 8'd0;
            numWords       <= 16'd0;
            wordIdx        <= 16'd0;
            byteIdx        <= 2'd0;
            asmReg         <= 24'd0;
            csum           <= 8'd0;
            idleCnt        <= '0;
        end else begin
            bus.imem_we   <= 1'b0;
            // Status flags follow the state being entered so they switch on that edge.
            bus.cpu_reset <= (nextState != S_RUN);
            bus.done      <= (nextState == S_RUN);
            bus.error     <= (nextState == S_ERROR);

            if (countIdle && !bus.rx_valid) idleCnt <= idleCnt + IW'(1);
            else                            idleCnt <= '0;

            case (state)
                S_CNT_HI: if (bus.rx_valid) cntHi <= bus.rx_byte;
                S_CNT_LO: begin
                    if (bus.rx_valid) begin
                        numWords <= rxCount;
                        wordIdx  <= 16'd0;
                        byteIdx  <= 2'd0;
                        csum     <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        asmReg  <= {asmReg[15:0], bus.rx_byte};
                        csum    <= csum ^ bus.rx_byte;
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_wdata <= {asmReg, bus.rx_byte};
                            bus.imem_addr  <= BASE_ADDR + {14'd0, wordIdx, 2'b00};
                            wordIdx        <= wordIdx + 16'd1;
                        end
                    end
                end
                S_RUN, S_ERROR: begin
                    if (bus.reload) begin
                        cntHi    <= 8'd0;
                        numWords <= 16'd0;
                        wordIdx  <= 16'd0;
                        byteIdx  <= 2'd0;
                        asmReg   <= 24'd0;
                        csum     <= 8'd0;
                        idleCnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed test-plan frames plus randomized frames, checked against a frame-level
// model of the expected memory writes and final RUN/ERROR outcome.
module tb_prog_loader;
    localparam int unsigned MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned TMO  = 16;

    logic clk = 1'b0;
    logic reset;
    prog_loader_if bus();

    prog_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nErr = 0;
    logic [63:0] gotQ[$];
    logic [63:0] expQ[$];
    logic [7:0]  frame[$];

    always @(negedge clk) if (!reset && bus.imem_we) gotQ.push_back({bus.imem_addr, bus.imem_wdata});

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: expected writes into expQ, returns 1 when the image should run.
    function automatic bit modelFrame();
        int n;
        logic [7:0] x;
        expQ.delete();
        if (frame.size() < 2) return 1'b0;
        n = int'({frame[0], frame[1]});
        if (n > int'(MAXW)) return 1'b0;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            expQ.push_back({BASE + 32'(4 * i),
                            frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]});
            for (int k = 0; k < 4; k++) x = x ^ frame[2+4*i+k];
        end
        if (frame.size() < 3 + 4 * n) return 1'b0;
        return frame[2+4*n] == x;
    endfunction

    task automatic sendByte(logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'($urandom);
    endtask

    task automatic idle(int c, bit noise);
        repeat (c) begin
            bus.reload = noise && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        bus.reload = 1'b0;
    endtask

    task automatic doReload();
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        gotQ.delete();
    endtask

    task automatic runFrame(string tag, int maxGap, bit noise);
        bit expRun;
        gotQ.delete();
        expRun = modelFrame();
        foreach (frame[i]) begin
            sendByte(frame[i]);
            if (maxGap > 0 && i != frame.size() - 1) idle($urandom_range(0, maxGap), noise);
        end
        idle(3, 1'b0);
        chk({tag, "_nwrites"}, 64'(gotQ.size()), 64'(expQ.size()));
        foreach (expQ[i]) if (i < gotQ.size()) chk($sformatf("%s_write%0d", tag, i), gotQ[i], expQ[i]);
        chk({tag, "_done"}, 64'(bus.done), 64'(expRun));
        chk({tag, "_error"}, 64'(bus.error), 64'(!expRun));
        chk({tag, "_cpu_reset"}, 64'(bus.cpu_reset), 64'(!expRun));
    endtask

    initial begin
        int n;
        int kind;
        logic [7:0] x;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.reload   = 1'b0;
        #1;
        chk("rst_we", 64'(bus.imem_we), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'(BASE));
        chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("single", 0, 1'b0);
        chk("single_word", gotQ.size() > 0 ? gotQ[0] : 64'hx, {32'h0, 32'h2008_0005});
        sendByte(8'hFF);
        idle(2, 1'b0);
        chk("run_ignores_rx_writes", 64'(gotQ.size()), 64'd1);
        chk("run_ignores_rx_done", 64'(bus.done), 64'd1);

        doReload();
        chk("reload_clears_done", 64'(bus.done), 64'd0);
        chk("reload_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
        runFrame("two_b2b", 0, 1'b0);
        chk("two_word1", gotQ.size() > 1 ? gotQ[1] : 64'hx, {32'h4, 32'hAC08_0000});

        // Reset in the middle of DATA, while imem_addr still holds 0x4 from the last frame.
        doReload();
        sendByte(8'h00); sendByte(8'h02); sendByte(8'h20); sendByte(8'h08);
        #2 reset = 1'b1;
        #1;
        chk("midrst_addr", 64'(bus.imem_addr), 64'(BASE));
        chk("midrst_wdata", 64'(bus.imem_wdata), 64'd0);
        chk("midrst_we", 64'(bus.imem_we), 64'd0);
        chk("midrst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        chk("midrst_error", 64'(bus.error), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("after_reset", 0, 1'b0);

        doReload();
        frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        runFrame("bad_chk", 0, 1'b0);
        doReload();
        frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("reload_ok", 0, 1'b0);

        doReload();
        frame = '{8'h01, 8'h01};
        runFrame("oversize", 0, 1'b0);
        doReload();
        frame = '{8'h00, 8'h00, 8'h00};
        runFrame("empty", 0, 1'b0);

        doReload();
        sendByte(8'h00); sendByte(8'h01); sendByte(8'h20);
        repeat (TMO - 1) @(negedge clk);
        chk("timeout_early_error", 64'(bus.error), 64'd0);
        chk("timeout_early_cpu_reset", 64'(bus.cpu_reset), 64'd1);
        @(negedge clk);
        chk("timeout_error", 64'(bus.error), 64'd1);
        chk("timeout_nwrites", 64'(gotQ.size()), 64'd0);

        for (int it = 0; it < 14; it++) begin
            doReload();
            frame.delete();
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                n = $urandom_range(MAXW + 1, 65535);
                frame.push_back(8'(n >> 8));
                frame.push_back(8'(n));
            end else begin
                n = $urandom_range(0, 8);
                frame.push_back(8'(n >> 8));
                frame.push_back(8'(n));
                x = 8'h00;
                for (int k = 0; k < 4 * n; k++) begin
                    frame.push_back(8'($urandom));
                    x = x ^ frame[frame.size() - 1];
                end
                frame.push_back(kind == 1 ? x ^ 8'($urandom_range(1, 255)) : x);
            end
            runFrame($sformatf("rand%0d", it), 3, 1'b1);
        end

        doReload();
        frame.delete();
        frame.push_back(8'h01);
        frame.push_back(8'h00);
        x = 8'h00;
        for (int k = 0; k < 4 * int'(MAXW); k++) begin
            frame.push_back(8'($urandom));
            x = x ^ frame[frame.size() - 1];
        end
        frame.push_back(x);
        runFrame("max_words", 0, 1'b0);
        chk("max_last_addr", gotQ.size() > 0 ? 64'(gotQ[gotQ.size() - 1][63:32]) : 64'hx,
            64'(BASE + 32'h3FC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
